// File: rtl/sar_search_controller.sv
// Successive-approximation search engine driving the B operand of an external
// combinational comparator. It recovers the unknown A operand one bit at a time,
// starting from the MSB, using the comparator's less/equal/greater verdicts.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   start             request a new search (accepted only while busy=0)
//   less/equal/greater comparator verdicts for the current guess
//   guess             trial value presented to comparator B
//   busy              search in progress
//   done              one-cycle pulse at the end of a search (normal or error)
//   found             equal was observed during the last search
//   error             an illegal verdict combination aborted the last search
//   result            recovered A value, held until the next search completes
//   steps             number of trials consumed by the last search
module sar_search_controller #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             less,
    input  logic                             equal,
    input  logic                             greater,
    output logic [WIDTH-1:0]                 guess,
    output logic                             busy,
    output logic                             done,
    output logic                             found,
    output logic                             error,
    output logic [WIDTH-1:0]                 result,
    output logic [$clog2(WIDTH+1)-1:0]       steps
);

    localparam int unsigned STEPS_W = $clog2(WIDTH + 1);
    localparam int unsigned IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [WIDTH-1:0]     r_guess;
    logic [WIDTH-1:0]     r_result;
    logic [STEPS_W-1:0]   r_steps;
    logic [IDX_W-1:0]     r_idx;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_found;
    logic                 r_error;

    logic                 w_start_ok;
    logic                 w_sample;
    logic                 w_legal;
    logic                 w_last_bit;
    logic [WIDTH-1:0]     w_mask;
    logic [WIDTH-1:0]     w_trial;
    logic [WIDTH-1:0]     w_next_probe;
    logic                 w_busy;
    logic                 w_done;

    // Search control decodes
    always_comb begin
        w_start_ok   = start && (r_state != ST_PROBE);
        w_sample     = (r_state == ST_PROBE) && (r_cnt == '0);
        w_legal      = $onehot({less, equal, greater});
        w_last_bit   = (r_idx == '0);
        w_mask       = WIDTH'(1) << r_idx;
        // Current bit decided by the verdict, then the next lower bit set as the new trial
        w_trial      = greater ? (r_guess | w_mask) : (r_guess & ~w_mask);
        w_next_probe = w_trial | (w_mask >> 1);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_state_next = ST_PROBE;
            end
            ST_PROBE: begin
                if (w_sample && (!w_legal || equal || w_last_bit)) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_state_next = w_start_ok ? ST_PROBE : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_PROBE: w_busy = 1'b1;
            ST_DONE:  w_done = 1'b1;
            default:  ;
        endcase
    end

    // Trial datapath: guess, bit index, settle counter and result bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_guess  <= '0;
            r_result <= '0;
            r_steps  <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_found  <= 1'b0;
            r_error  <= 1'b0;
        end else if (w_start_ok) begin
            r_guess  <= WIDTH'(1) << (WIDTH - 1);
            r_idx    <= IDX_W'(WIDTH - 1);
            r_cnt    <= CNT_W'(SETTLE_CYCLES - 1);
            r_steps  <= '0;
            r_found  <= 1'b0;
            r_error  <= 1'b0;
        end else if (w_sample) begin
            r_steps <= r_steps + STEPS_W'(1);
            if (!w_legal) begin
                r_error  <= 1'b1;
                r_found  <= 1'b0;
                r_result <= '0;
            end else if (equal) begin
                r_result <= r_guess;
                r_found  <= 1'b1;
            end else if (w_last_bit) begin
                r_guess  <= w_trial;
                r_result <= w_trial;
                r_found  <= 1'b0;
            end else begin
                r_guess <= w_next_probe;
                r_idx   <= r_idx - IDX_W'(1);
                r_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
            end
        end else if (r_state == ST_PROBE) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign guess  = r_guess;
    assign result = r_result;
    assign steps  = r_steps;
    assign found  = r_found;
    assign error  = r_error;
    assign busy   = w_busy;
    assign done   = w_done;

endmodule

// File: tb/tb_sar_search_controller.sv
// Directed bench for sar_search_controller: two instances (settle 1 and settle 3),
// each paired with a behavioural comparator that can be overridden per trial.
module tb_sar_search_controller;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;

    // SETTLE_CYCLES = 1 instance
    logic         start1;
    logic         less1, equal1, greater1;
    logic [W-1:0] guess1, result1;
    logic         busy1, done1, found1, error1;
    logic [2:0]   steps1;
    logic [W-1:0] a1;
    logic         use_ovr;
    logic [2:0]   ovr;      // {less, equal, greater}

    // SETTLE_CYCLES = 3 instance
    logic         start3;
    logic         less3, equal3, greater3;
    logic [W-1:0] guess3, result3;
    logic         busy3, done3, found3, error3;
    logic [2:0]   steps3;
    logic [W-1:0] a3;

    int checks = 0;
    int errors = 0;

    sar_search_controller #(.WIDTH(W), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .less(less1), .equal(equal1), .greater(greater1),
        .guess(guess1), .busy(busy1), .done(done1), .found(found1),
        .error(error1), .result(result1), .steps(steps1)
    );

    sar_search_controller #(.WIDTH(W), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .less(less3), .equal(equal3), .greater(greater3),
        .guess(guess3), .busy(busy3), .done(done3), .found(found3),
        .error(error3), .result(result3), .steps(steps3)
    );

    // Comparator models: A is the hidden operand, B is the DUT guess
    always_comb begin
        if (use_ovr) begin
            {less1, equal1, greater1} = ovr;
        end else begin
            less1    = (a1 <  guess1);
            equal1   = (a1 == guess1);
            greater1 = (a1 >  guess1);
        end
        less3    = (a3 <  guess3);
        equal3   = (a3 == guess3);
        greater3 = (a3 >  guess3);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] exp_g;
        rst_n   = 1'b0;
        start1  = 1'b0;
        start3  = 1'b0;
        a1      = '0;
        a3      = '0;
        use_ovr = 1'b0;
        ovr     = 3'b000;
        tick();
        tick();

        // Reset state
        check("rst_guess",  32'(guess1),  32'h0);
        check("rst_result", 32'(result1), 32'h0);
        check("rst_steps",  32'(steps1),  32'h0);
        check("rst_flags",  32'({busy1, done1, found1, error1}), 32'h0);
        rst_n = 1'b1;
        tick();

        // A = 0110: guesses 1000, 0100, 0110 then equal
        a1 = 4'b0110;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("t1_g0",    32'(guess1), 32'h8);
        check("t1_busy",  32'(busy1),  32'h1);
        tick();
        check("t1_g1",    32'(guess1), 32'h4);
        tick();
        check("t1_g2",    32'(guess1), 32'h6);
        check("t1_nodone", 32'(done1), 32'h0);
        tick();
        check("t1_done",  32'({done1, busy1}), 32'h2);
        check("t1_result", 32'(result1), 32'h6);
        check("t1_found", 32'(found1), 32'h1);
        check("t1_steps", 32'(steps1), 32'h3);
        tick();
        check("t1_idle",  32'({done1, busy1}), 32'h0);
        check("t1_hold",  32'(result1), 32'h6);

        // A = 0: every trial less
        a1 = 4'b0000;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("t2_g0", 32'(guess1), 32'h8);
        tick();
        check("t2_g1", 32'(guess1), 32'h4);
        tick();
        check("t2_g2", 32'(guess1), 32'h2);
        tick();
        check("t2_g3", 32'(guess1), 32'h1);
        tick();
        check("t2_done",   32'(done1),   32'h1);
        check("t2_result", 32'(result1), 32'h0);
        check("t2_flags",  32'({found1, error1}), 32'h0);
        check("t2_steps",  32'(steps1),  32'h4);
        tick();

        // A = 1111: equal on the 4th trial
        a1 = 4'b1111;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("t3_g0", 32'(guess1), 32'h8);
        tick();
        check("t3_g1", 32'(guess1), 32'hC);
        tick();
        check("t3_g2", 32'(guess1), 32'hE);
        tick();
        check("t3_g3", 32'(guess1), 32'hF);
        tick();
        check("t3_done",   32'(done1),   32'h1);
        check("t3_result", 32'(result1), 32'hF);
        check("t3_found",  32'(found1),  32'h1);
        check("t3_steps",  32'(steps1),  32'h4);
        tick();

        // Greater forced on every trial, including bit 0: bit kept, not found
        use_ovr = 1'b1;
        ovr = 3'b001;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        tick();
        check("t4_g3", 32'(guess1), 32'hF);
        tick();
        check("t4_done",   32'(done1),   32'h1);
        check("t4_result", 32'(result1), 32'hF);
        check("t4_flags",  32'({found1, error1}), 32'h0);
        check("t4_steps",  32'(steps1),  32'h4);
        use_ovr = 1'b0;
        tick();

        // Illegal verdict on trial 2, start mid-search ignored, restart in DONE cycle
        a1 = 4'b0110;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("t5_g0", 32'(guess1), 32'h8);
        tick();
        check("t5_g1", 32'(guess1), 32'h4);
        use_ovr = 1'b1;
        ovr = 3'b101;
        start1 = 1'b1;
        tick();
        check("t5_done",   32'({done1, busy1}), 32'h2);
        check("t5_error",  32'(error1),  32'h1);
        check("t5_result", 32'(result1), 32'h0);
        check("t5_found",  32'(found1),  32'h0);
        check("t5_steps",  32'(steps1),  32'h2);
        use_ovr = 1'b0;
        tick();
        start1 = 1'b0;
        check("t5_restart_busy",  32'({done1, busy1}), 32'h1);
        check("t5_restart_guess", 32'(guess1), 32'h8);
        check("t5_restart_clear", 32'({error1, steps1}), 32'h0);
        tick();
        tick();
        tick();
        check("t5_done2",   32'(done1),   32'h1);
        check("t5_result2", 32'({found1, error1, result1}), 32'h26);
        tick();

        // Asynchronous reset between edges mid-search
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        check("t6_pre", 32'(guess1), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_guess", 32'(guess1), 32'h0);
        check("t6_async_flags", 32'({busy1, done1, found1, error1}), 32'h0);
        check("t6_async_res",   32'({result1, steps1}), 32'h0);
        tick();
        check("t6_nodone", 32'({done1, busy1}), 32'h0);
        rst_n = 1'b1;
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        tick();
        check("t6_done",   32'(done1),   32'h1);
        check("t6_result", 32'(result1), 32'h6);
        check("t6_steps",  32'(steps1),  32'h3);
        tick();

        // SETTLE_CYCLES=3, A=1010: trials 1000 (gt), 1100 (lt), 1010 (eq), each held 3 cycles
        a3 = 4'b1010;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        check("s3_g0", 32'(guess3), 32'h8);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k < 9) begin
                exp_g = (k < 3) ? 4'h8 : ((k < 6) ? 4'hC : 4'hA);
                check($sformatf("s3_g%0d", k), 32'({done3, guess3}), 32'(exp_g));
            end
        end
        check("s3_done",   32'({done3, busy3}), 32'h2);
        check("s3_result", 32'(result3), 32'hA);
        check("s3_found",  32'(found3),  32'h1);
        check("s3_steps",  32'(steps3),  32'h3);
        tick();
        check("s3_idle",   32'({done3, busy3}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
